muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the MIPS datapath, next to the ALU. Executes MULT, MULTU, DIV, DIVU and MTHI/MTLO into private HI/LO registers over multiple cycles. Reports `busy` so the control unit can stall MFHI/MFLO and further mul/div issue, and reports `done` on completion. Width is parametric; 32 is the datapath default.

---
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with private HI/LO registers for the MIPS datapath.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles; MTHI/MTLO complete in a single cycle.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO are handled here
// S_CALC | one shift-add or shift-subtract iteration per cycle, WIDTH cycles
// S_FIX  | sign correction, HI/LO write, done pulse
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] mag_b;
    logic             is_div, neg_res, neg_rem, zero_div;

    logic             issue, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] rem_nxt, quo_mag, rem_mag;
    logic [2*WIDTH-1:0] prod;

    assign issue    = (state == S_IDLE) && start && !op[2];
    assign a_neg    = !op[0] && a[WIDTH-1];
    assign b_neg    = !op[0] && b[WIDTH-1];
    assign mag_a_in = a_neg ? -a : a;
    assign mag_b_in = b_neg ? -b : b;
    assign busy     = (state != S_IDLE);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, mag_b});
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign rem_nxt   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

    assign prod    = neg_res ? -acc : acc;
    assign quo_mag = acc[WIDTH-1:0];
    assign rem_mag = acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue) state_nxt = S_CALC;
            S_CALC:  if (cnt == CW'(WIDTH-1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            mag_b       <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            zero_div    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        acc      <= {{WIDTH{1'b0}}, mag_a_in};
                        mag_b    <= mag_b_in;
                        is_div   <= op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        zero_div <= op[1] && (b == '0);
                        cnt      <= '0;
                    end else if (start && op == 3'b100) begin
                        hi <= a;
                    end else if (start && op == 3'b101) begin
                        lo <= a;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) acc <= {rem_nxt, acc[WIDTH-2:0], div_ok};
                    else        acc <= {mul_sum, acc[WIDTH-1:1]};
                end
                S_FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= zero_div;
                    if (is_div) begin
                        // Zero divisor: remainder path already reproduces a; quotient forced to all ones.
                        lo <= zero_div ? '1 : (neg_res ? -quo_mag : quo_mag);
                        hi <= neg_rem ? -rem_mag : rem_mag;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against an
// arithmetic reference model, and hand sequences for back-to-back issue and reset abort.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, exp_hi, exp_lo;
        logic         exp_dbz;
    } vec_t;

    vec_t vecs[8];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        longint sa, sb, sq, sr;
        logic [63:0] p, q64, r64;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        z = 1'b0;
        h = '0;
        l = '0;
        case (mop)
            3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = {32'b0, ma} * {32'b0, mb}; h = p[63:32]; l = p[31:0]; end
            3'd2, 3'd3: begin
                if (mb == 0) begin
                    h = ma; l = '1; z = 1'b1;
                end else if (mop == 3'd2) begin
                    sq = sa / sb; sr = sa % sb;
                    q64 = sq; r64 = sr;
                    l = q64[31:0]; h = r64[31:0];
                end else begin
                    l = ma / mb; h = ma % mb;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one mul/div and wait for done; optionally pulse MTLO on start at CALC cycle inj.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input int inj, output int lat, output int busy_cyc, output int n_done);
        logic overlap;
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0; n_done = 0; overlap = 1'b0;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < W + 8) begin
            if (lat == inj) begin
                start = 1'b1; op = 3'b101; a = 32'hDEAD;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (busy) busy_cyc++;
            if (done) n_done++;
            if (busy && done) overlap = 1'b1;
        end
        check("busy_done_overlap", 64'(overlap), 64'd0);
    endtask

    initial begin
        int lat, bc, nd;
        logic [W-1:0] eh, el;
        logic ez;

        vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4] = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
        vecs[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[6] = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[7] = '{3'd3, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0};

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        #23;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat, bc, nd);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(W + 1));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(W + 1));
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            check($sformatf("vec%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].exp_dbz));
        end

        for (int i = 0; i < 60; i++) begin
            logic [2:0] ro;
            logic [W-1:0] ra, rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h80000000;
                default: rb = $urandom;
            endcase
            if (ra == 32'h80000000 && $urandom_range(0, 1) == 1) rb = 32'hFFFFFFFF;
            model(ro, ra, rb, eh, el, ez);
            run_op(ro, ra, rb, -1, lat, bc, nd);
            check($sformatf("rnd%0d_op%0d_hi", i, ro), 64'(hi), 64'(eh));
            check($sformatf("rnd%0d_op%0d_lo", i, ro), 64'(lo), 64'(el));
            check($sformatf("rnd%0d_op%0d_dbz", i, ro), 64'(div_by_zero), 64'(ez));
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(W + 1));
        end

        // MTHI then back-to-back MULTU with an MTLO attempted mid-CALC.
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'h1234; b = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        run_op(3'd1, 32'd2, 32'd3, 4, lat, bc, nd);
        check("b2b_lo", 64'(lo), 64'd6);
        check("b2b_hi", 64'(hi), 64'd0);
        check("b2b_done_pulses", 64'(nd), 64'd1);
        check("b2b_latency", 64'(lat), 64'(W + 1));
        @(posedge clk); #1;
        check("b2b_done_drops", 64'(done), 64'd0);
        check("b2b_lo_hold", 64'(lo), 64'd6);

        // Reset during CALC aborts the divide.
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (W + 8) begin @(posedge clk); #1; if (done) nd++; end
        check("abort_no_done", 64'(nd), 64'd0);
        run_op(3'd3, 32'd100, 32'd7, -1, lat, bc, nd);
        check("post_reset_lo", 64'(lo), 64'd14);
        check("post_reset_hi", 64'(hi), 64'd2);
        check("post_reset_latency", 64'(lat), 64'(W + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
